// File: rtl/rl_pkg.sv
// Shared types and constants for the two-agent Q-learning datapath.
// Includes the Galois LFSR next-state helper used by the exploration source.
package rl_pkg;
  localparam int ACT_W = 2;
  localparam int EPS_W = 8;
  localparam logic [15:0] LFSR_TAPS      = 16'hB400;
  localparam logic [15:0] LFSR_SAFE_SEED = 16'hACE1;

  typedef logic [ACT_W-1:0] action_t;

  // Right-shifting Galois step: the bit shifted out selects the tap mask.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    lfsr_next = (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction
endpackage

// File: rtl/lfsr16_galois.sv
// 16-bit maximal-length Galois LFSR that advances once per adv pulse.
// A zero seed would lock the register, so it is replaced by a safe seed.
module lfsr16_galois
  import rl_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SAFE_SEED
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        adv,
  output logic [15:0] state
);
  localparam logic [15:0] SEED_SAFE = (SEED == 16'h0000) ? LFSR_SAFE_SEED : SEED;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SEED_SAFE;
    end else if (adv) begin
      state <= lfsr_next(state);
    end
  end
endmodule

// File: rtl/eps_greedy_gen.sv
// Epsilon-greedy exploration source: one random action and greedy/explore bit
// per agent per step, with epsilon decayed on episode boundaries to a floor.
module eps_greedy_gen
  import rl_pkg::*;
#(
  parameter logic [15:0]      SEED_A       = 16'hACE1,
  parameter logic [15:0]      SEED_B       = 16'h1D2B,
  parameter logic [EPS_W-1:0] EPS_INIT     = 8'd230,
  parameter logic [EPS_W-1:0] EPS_MIN      = 8'd13,
  parameter logic [EPS_W-1:0] DECAY_STEP   = 8'd8,
  parameter logic [15:0]      DECAY_PERIOD = 16'd10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  input  logic             episode_done,
  input  logic             decay_en,
  output action_t          Arand_A,
  output action_t          Arand_B,
  output logic             Asel_A,
  output logic             Asel_B,
  output logic             valid,
  output logic [EPS_W-1:0] eps_cur
);
  localparam logic [15:0] SEED_A_SAFE = (SEED_A == 16'h0000) ? 16'hACE1 : SEED_A;
  localparam logic [15:0] SEED_B_SAFE = (SEED_B == 16'h0000) ? 16'h1D2B : SEED_B;
  // Nine-bit threshold so EPS_MIN + DECAY_STEP cannot wrap.
  localparam logic [EPS_W:0] DECAY_THRESH = {1'b0, EPS_MIN} + {1'b0, DECAY_STEP};
  localparam logic [15:0]    EP_LAST      = DECAY_PERIOD - 16'd1;

  logic [15:0]      state_a;
  logic [15:0]      state_b;
  logic [15:0]      r_a;
  logic [15:0]      r_b;
  logic [EPS_W-1:0] eps;
  logic [15:0]      ep_cnt;
  logic             unused_hi;

  lfsr16_galois #(.SEED(SEED_A_SAFE)) u_lfsr_a (
    .clk   (clk),
    .rst   (rst),
    .adv   (step),
    .state (state_a)
  );

  lfsr16_galois #(.SEED(SEED_B_SAFE)) u_lfsr_b (
    .clk   (clk),
    .rst   (rst),
    .adv   (step),
    .state (state_b)
  );

  // Post-shift values: the same values the LFSRs load at this edge.
  assign r_a       = lfsr_next(state_a);
  assign r_b       = lfsr_next(state_b);
  assign unused_hi = ^{r_a[15:10], r_b[15:10]};

  // Output handshake: valid pulses for exactly one cycle with each new pair;
  // there is no ready, the consumer must take the pair in that cycle, and
  // Arand_*/Asel_* hold their values until the next step.
  always_ff @(posedge clk) begin
    if (rst) begin
      Arand_A <= '0;
      Arand_B <= '0;
      Asel_A  <= 1'b0;
      Asel_B  <= 1'b0;
      valid   <= 1'b0;
    end else begin
      valid <= step;
      if (step) begin
        Arand_A <= r_a[9:8];
        Arand_B <= r_b[9:8];
        Asel_A  <= (r_a[7:0] >= eps);
        Asel_B  <= (r_b[7:0] >= eps);
      end
    end
  end

  // A coincident step above reads eps before this edge updates it.
  always_ff @(posedge clk) begin
    if (rst) begin
      eps    <= EPS_INIT;
      ep_cnt <= 16'd0;
    end else if (episode_done && decay_en) begin
      if (ep_cnt == EP_LAST) begin
        ep_cnt <= 16'd0;
        if ({1'b0, eps} < DECAY_THRESH) begin
          eps <= EPS_MIN;
        end else begin
          eps <= eps - DECAY_STEP;
        end
      end else begin
        ep_cnt <= ep_cnt + 16'd1;
      end
    end
  end

  assign eps_cur = eps;
endmodule

// File: tb/tb_eps_greedy_gen.sv
// Directed bench for eps_greedy_gen: a reference LFSR/epsilon model fills an
// expected queue on each step, popped whenever the DUT presents valid.
module tb_eps_greedy_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic step = 1'b0;
  logic episode_done = 1'b0;
  logic decay_en = 1'b1;

  logic [1:0] d_arand_a, d_arand_b, e_arand_a, e_arand_b, z_arand_a, z_arand_b;
  logic       d_asel_a, d_asel_b, e_asel_a, e_asel_b, z_asel_a, z_asel_b;
  logic       d_valid, e_valid, z_valid;
  logic [7:0] d_eps, e_eps, z_eps;

  int n_tests = 0;
  int n_fail  = 0;
  int z_vcnt  = 0;

  logic [5:0] exp_q[$];

  logic [15:0] ma, mb;
  logic [7:0]  eps_m;
  int          ep_m;

  always #5 clk = ~clk;

  // Default parameters: decay behaviour and scoreboard.
  eps_greedy_gen dut (
    .clk(clk), .rst(rst), .step(step), .episode_done(episode_done), .decay_en(decay_en),
    .Arand_A(d_arand_a), .Arand_B(d_arand_b), .Asel_A(d_asel_a), .Asel_B(d_asel_b),
    .valid(d_valid), .eps_cur(d_eps)
  );

  // eps = 0x80, frozen: known first-step values.
  eps_greedy_gen #(.EPS_INIT(8'h80)) dut_e (
    .clk(clk), .rst(rst), .step(step), .episode_done(episode_done), .decay_en(1'b0),
    .Arand_A(e_arand_a), .Arand_B(e_arand_b), .Asel_A(e_asel_a), .Asel_B(e_asel_b),
    .valid(e_valid), .eps_cur(e_eps)
  );

  // eps = 0, frozen: always greedy, LFSR period.
  eps_greedy_gen #(.EPS_INIT(8'd0)) dut_z (
    .clk(clk), .rst(rst), .step(step), .episode_done(episode_done), .decay_en(1'b0),
    .Arand_A(z_arand_a), .Arand_B(z_arand_b), .Asel_A(z_asel_a), .Asel_B(z_asel_b),
    .valid(z_valid), .eps_cur(z_eps)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [15:0] m_next(input logic [15:0] s);
    logic b;
    b = s[0];
    s = s >> 1;
    if (b) s = s ^ 16'hB400;
    return s;
  endfunction

  task automatic model_reset();
    ma    = 16'hACE1;
    mb    = 16'h1D2B;
    eps_m = 8'd230;
    ep_m  = 0;
  endtask

  // Drive one cycle; the model consumes the step before the episode update.
  task automatic do_cycle(input bit s, input bit ed);
    step         = s;
    episode_done = ed;
    if (!rst) begin
      if (s) begin
        ma = m_next(ma);
        mb = m_next(mb);
        exp_q.push_back({ma[9:8], ma[7:0] >= eps_m, mb[9:8], mb[7:0] >= eps_m});
      end
      if (ed && decay_en) begin
        if (ep_m == 9) begin
          ep_m  = 0;
          eps_m = (eps_m < 8'd21) ? 8'd13 : eps_m - 8'd8;
        end else begin
          ep_m++;
        end
      end
    end
    @(posedge clk);
    #1;
    step         = 1'b0;
    episode_done = 1'b0;
  endtask

  task automatic episodes(input int n);
    for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b1);
  endtask

  always @(negedge clk) begin
    if (z_valid) z_vcnt++;
    if (d_valid) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_valid", 32'd1, 32'd0);
      end else begin
        chk("sb_pair", {26'd0, d_arand_a, d_asel_a, d_arand_b, d_asel_b}, {26'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    model_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", d_valid, 1'b0);
    chk("rst_arand", {d_arand_a, d_arand_b}, 4'd0);
    chk("rst_asel", {d_asel_a, d_asel_b}, 2'd0);
    chk("rst_eps_def", d_eps, 8'd230);
    chk("rst_eps_80", e_eps, 8'h80);
    chk("rst_ep_cnt", dut.ep_cnt, 16'd0);
    rst = 1'b0;

    // First step from seed ACE1: r = E270.
    do_cycle(1'b1, 1'b0);
    chk("first_valid", e_valid, 1'b1);
    chk("first_arand_a", e_arand_a, 2'd2);
    chk("first_asel_a", e_asel_a, 1'b0);
    do_cycle(1'b0, 1'b0);
    chk("valid_one_cycle", e_valid, 1'b0);
    chk("hold_arand_a", e_arand_a, 2'd2);
    for (int i = 0; i < 5; i++) do_cycle(1'b1, 1'b0);
    episodes(10);
    chk("eps_before_rst", d_eps, 8'd222);

    // Reset coincident with a step wins.
    rst = 1'b1;
    do_cycle(1'b1, 1'b1);
    chk("mid_rst_valid", d_valid | e_valid | z_valid, 1'b0);
    chk("mid_rst_arand", {d_arand_a, d_arand_b, e_arand_a}, 6'd0);
    chk("mid_rst_asel", {d_asel_a, d_asel_b}, 2'd0);
    chk("mid_rst_eps", d_eps, 8'd230);
    rst = 1'b0;
    model_reset();
    do_cycle(1'b1, 1'b0);
    chk("post_rst_arand_a", e_arand_a, 2'd2);
    chk("post_rst_asel_a", e_asel_a, 1'b0);

    // Decay schedule and step/episode coincidence at eps = 222.
    episodes(10);
    chk("eps_ep10", d_eps, 8'd222);
    chk("frozen_eps_80", e_eps, 8'h80);
    episodes(9);
    do_cycle(1'b1, 1'b1);
    chk("eps_ep20", d_eps, 8'd214);
    do_cycle(1'b1, 1'b0);

    // Decay disabled: counter and epsilon hold, then resume.
    episodes(3);
    decay_en = 1'b0;
    episodes(25);
    chk("held_eps", d_eps, 8'd214);
    chk("held_ep_cnt", dut.ep_cnt, 16'd3);
    decay_en = 1'b1;
    episodes(6);
    chk("resume_ep_cnt", dut.ep_cnt, 16'd9);
    chk("resume_eps_pre", d_eps, 8'd214);
    episodes(1);
    chk("resume_eps", d_eps, 8'd206);

    // Random mix of steps, episodes and decay enables.
    for (int i = 0; i < 300; i++) begin
      decay_en = ($urandom_range(0, 3) != 0);
      do_cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0));
      if (i % 50 == 0) chk("rand_eps", d_eps, eps_m);
    end
    decay_en = 1'b1;

    // Saturation at the floor.
    episodes(300);
    chk("eps_floor", d_eps, 8'd13);
    for (int i = 0; i < 5; i++) do_cycle(1'b1, 1'b0);
    episodes(40);
    chk("eps_floor_stays", d_eps, 8'd13);

    // eps = 0: always greedy; full LFSR period returns to the seed.
    rst = 1'b1;
    do_cycle(1'b0, 1'b0);
    rst = 1'b0;
    model_reset();
    z_vcnt = 0;
    for (int i = 0; i < 65535; i++) begin
      do_cycle(1'b1, 1'b0);
      if (i < 1000) chk("eps0_asel", {z_asel_a, z_asel_b}, 2'b11);
      if (i == 999) begin
        do_cycle(1'b0, 1'b0);
        chk("eps0_valid_count", z_vcnt, 32'd1000);
      end
    end
    chk("lfsr_period", dut_z.u_lfsr_a.state, 16'hACE1);
    do_cycle(1'b0, 1'b0);
    chk("sb_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/eps_greedy_gen.md
# eps_greedy_gen

- Epsilon-greedy exploration source for the two-agent (A/B) Q-learning datapath; sits directly upstream of the policy generator.
- Per decision step, produces one random action and one greedy/explore select bit per agent; feeds them straight into the policy generator's `Arand_*`/`Asel_*` inputs.
- Owns the exploration rate epsilon and decays it on episode boundaries down to a floor.

## Interface
- `SEED_A`, default 16'hACE1: LFSR seed, agent A. A value of 0 is replaced by 16'hACE1.
- `SEED_B`, default 16'h1D2B: LFSR seed, agent B. A value of 0 is replaced by 16'h1D2B.
- `EPS_INIT`, default 8'd230: epsilon after reset. Exploration probability is eps/256.
- `EPS_MIN`, default 8'd13: epsilon floor.
- `DECAY_STEP`, default 8'd8: amount subtracted from epsilon per decay event.
- `DECAY_PERIOD`, default 16'd10: episodes per decay event. Must be ≥1.

Ports (clock and reset first):
- `clk`  in  1: single clock.
- `rst`  in  1: synchronous, active-high reset.
- `step`  in  1: one-cycle pulse requesting a new action pair.
- `episode_done`  in  1: one-cycle pulse marking an episode end.
- `decay_en`  in  1: 1 = decay allowed; 0 = epsilon frozen, episode counter held.
- `Arand_A`, `Arand_B`  out  2: random action per agent.
- `Asel_A`, `Asel_B`  out  1: 1 = greedy, 0 = explore (the policy generator takes greedy when `Asel & learning`).
- `valid`  out  1: one-cycle pulse when a new pair is presented.
- `eps_cur`  out  8: current epsilon.

## Operation
- Two independent 16-bit Galois LFSRs, one per agent.
- LFSR update (right shift): `lsb = s[0]; s = s >> 1; if (lsb) s ^= 16'hB400`.
- LFSRs advance exactly once per `step`; otherwise they hold.
- Outputs are derived from the post-shift value `r`:
  - `Arand = r[9:8]`.
  - `Asel = (r[7:0] >= eps)`.
  - With eps = 0, `Asel` is always 1.
- Both agents compare against the same `eps`.
- `Arand_*`/`Asel_*` are registered and hold between steps.
- Episode counter `ep_cnt` (16 bit):
  - On `episode_done & decay_en`: if `ep_cnt == DECAY_PERIOD-1`, clear `ep_cnt` and run a decay event; else increment `ep_cnt`.
  - Decay event: `eps <= (eps < EPS_MIN + DECAY_STEP) ? EPS_MIN : eps - DECAY_STEP`.
  - Compute the decay compare in 9 bits; no underflow or wrap.
  - Once `eps == EPS_MIN`, it stays there.
- If `EPS_INIT < EPS_MIN`, epsilon starts at `EPS_INIT` and the first decay event sets it to `EPS_MIN`. The saturation rule covers this case.
- `episode_done` with `decay_en = 0`: no state change.

## Timing
- Reset values:
  - LFSRs = seeds.
  - `eps` = `EPS_INIT`, `ep_cnt` = 0.
  - `Arand_A`, `Arand_B` = 0.
  - `Asel_A`, `Asel_B` = 0.
  - `valid` = 0.
  - `eps_cur` = `EPS_INIT`.
- Latency: `step` high at edge t → new outputs and `valid` = 1 visible after edge t+1, for one cycle.
- Back-to-back `step` on every cycle is legal: one new pair per cycle.
- `step` and `episode_done` in the same cycle: the step compares against the pre-decay eps; the new eps applies from the next step.
- `eps_cur` updates one cycle after the decaying `episode_done`.
- `rst` mid-operation overrides everything in that cycle, including a coincident `step` or `episode_done`.
- No combinational path from inputs to outputs.

## Structure
- Shared package `rl_pkg`:
  - `ACT_W = 2`, `EPS_W = 8`.
  - `LFSR_TAPS = 16'hB400`.
  - `LFSR_SAFE_SEED = 16'hACE1`.
  - Typedef `action_t` (`logic [ACT_W-1:0]`).
- Sub-module `lfsr16_galois`: ports `clk`, `rst`, `adv`, param `SEED`, output `state[15:0]`. Instantiated twice (A, B).
- Top-level logic: compare/select registers, episode counter, epsilon register.

## Test plan
- Reset with `SEED_A` = 16'hACE1, `EPS_INIT` = 8'h80, single `step`:
  - Requires `r_A` = 16'hE270 → `Arand_A` = 2, `Asel_A` = 0 (8'h70 < 8'h80), `valid` high exactly one cycle at t+1.
- `EPS_INIT` = 0, 1000 consecutive steps:
  - Requires `Asel_A` = `Asel_B` = 1 every step.
  - `valid` count = 1000.
  - Agent A LFSR state after 65535 steps equals the seed (maximal period).
- `DECAY_PERIOD` = 10, `DECAY_STEP` = 8, `EPS_MIN` = 13, `EPS_INIT` = 230, repeated `episode_done`:
  - Requires `eps_cur` = 222 after episode 10, 214 after episode 20.
  - Saturates at 13 and stays at 13.
- Simultaneous `step` and decaying `episode_done` at eps = 222:
  - Requires that step's `Asel` to use 222.
  - Requires the next step to use 214.
- `decay_en` = 0 for 25 `episode_done` pulses:
  - Requires `eps_cur` and `ep_cnt` unchanged.
  - Re-enabling resumes the count from the held value.
- `rst` asserted mid-stream coincident with `step`:
  - Requires all outputs at reset values, no `valid`.
  - Next `step` reproduces the same first-step output as after power-on reset.
